// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Input select for the mux-fed datapath registers
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_LOAD  = 2'b01,
        SEL_SHIFT = 2'b10,
        SEL_CLEAR = 2'b11
    } mux_sel_e;

    // Iteration counter width: ceil(log2 n), never below one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl_mux_dff.sv
// Register cell with a 4:1 input mux (hold / load / shift / clear) and async active-low clear.
import seq_mult_pkg::*;

module mux_dff #(
    parameter int unsigned W = 4
) (
    input  logic         CLK,
    input  logic         CLRn,
    input  mux_sel_e     sel,
    input  logic [W-1:0] load_d,
    input  logic [W-1:0] shift_d,
    output logic [W-1:0] q
);

    // Mux-selected next value, cleared asynchronously
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            q <= '0;
        end else begin
            case (sel)
                SEL_HOLD:  q <= q;
                SEL_LOAD:  q <= load_d;
                SEL_SHIFT: q <= shift_d;
                SEL_CLEAR: q <= '0;
            endcase
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: controller FSM plus mux-fed datapath.
// Optional overflow flag output enabled by defining SEQMULT_OVF_EN.
import seq_mult_pkg::*;

module seq_mult_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic           CLK,
    input  logic           CLRn,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
`ifdef SEQMULT_OVF_EN
    output logic           ovf,
`endif
    output logic [2*N-1:0] P
);

    localparam int unsigned CW = cnt_width(N);
    localparam int unsigned AW = N + 1;
    localparam int unsigned PW = 2 * N;

    state_e          state;
    logic [N-1:0]    mcand;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [N-1:0]    mplr;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   acc_next;
    logic [N-1:0]    mplr_next;
    logic [PW-1:0]   p_next;
    logic            last;
    mux_sel_e        acc_sel;
    mux_sel_e        mplr_sel;
    mux_sel_e        p_sel;

    // One add-and-shift step of {acc, mplr}
    always_comb begin
        addend    = mplr[0] ? {1'b0, mcand} : '0;
        sum       = acc + addend;
        acc_next  = {1'b0, sum[N:1]};
        mplr_next = {sum[0], mplr[N-1:1]};
        p_next    = {acc_next[N-1:0], mplr_next};
        last      = (cnt == CW'(N - 1));
    end

    // Datapath register selects decoded from the controller state
    always_comb begin
        acc_sel  = SEL_HOLD;
        mplr_sel = SEL_HOLD;
        p_sel    = SEL_HOLD;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_sel  = SEL_CLEAR;
                    mplr_sel = SEL_LOAD;
                end
            end
            CALC: begin
                acc_sel  = SEL_SHIFT;
                mplr_sel = SEL_SHIFT;
                if (last) begin
                    p_sel = SEL_LOAD;
                end
            end
            default: ;
        endcase
    end

    mux_dff #(.W(AW)) u_acc (
        .CLK     (CLK),
        .CLRn    (CLRn),
        .sel     (acc_sel),
        .load_d  ('0),
        .shift_d (acc_next),
        .q       (acc)
    );

    mux_dff #(.W(N)) u_mplr (
        .CLK     (CLK),
        .CLRn    (CLRn),
        .sel     (mplr_sel),
        .load_d  (B),
        .shift_d (mplr_next),
        .q       (mplr)
    );

    mux_dff #(.W(PW)) u_p (
        .CLK     (CLK),
        .CLRn    (CLRn),
        .sel     (p_sel),
        .load_d  (p_next),
        .shift_d ('0),
        .q       (P)
    );

    // Controller FSM with registered busy/done, multiplicand and iteration count
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            mcand <= '0;
            cnt   <= '0;
`ifdef SEQMULT_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= A;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SEQMULT_OVF_EN
                        ovf   <= |p_next[PW-1:N];
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed self-checking bench for seq_mult_ctrl (N=4).
module tb_seq_mult_ctrl;

    logic       CLK;
    logic       CLRn;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;
`ifdef SEQMULT_OVF_EN
    logic       ovf;
`endif

    int n_cmp;
    int n_fail;

    seq_mult_ctrl #(.N(4)) dut (
        .CLK   (CLK),
        .CLRn  (CLRn),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
`ifdef SEQMULT_OVF_EN
        .ovf   (ovf),
`endif
        .P     (P)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One product; optional poke of start with other operands after edge poke_at
    task automatic mult(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_p, input int poke_at);
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [7:0] p_at_done;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_at   = -1;
        p_at_done = 8'h00;
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at   = i;
                p_at_done = P;
`ifdef SEQMULT_OVF_EN
                check({tag, "_ovf"}, 16'(ovf), 16'(exp_p[7:4] != 4'h0));
`endif
            end
            if (i == poke_at) begin
                A = 4'hF;
                B = 4'hF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check({tag, "_p"}, 16'(p_at_done), 16'(exp_p));
        check({tag, "_done_edge"}, 16'(done_at), 16'd4);
        check({tag, "_done_cnt"}, 16'(done_cnt), 16'd1);
        check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd5);
        check({tag, "_p_hold"}, 16'(P), 16'(exp_p));
    endtask

    initial begin
        int d1;
        int d2;
        int n_done;
        int stray;
        logic [7:0] p1;
        logic [7:0] p2;
        n_cmp  = 0;
        n_fail = 0;
        CLRn  = 1'b0;
        start = 1'b0;
        A = 4'h0;
        B = 4'h0;
        #2;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_p", 16'(P), 16'd0);
`ifdef SEQMULT_OVF_EN
        check("rst_ovf", 16'(ovf), 16'd0);
`endif
        #10;
        CLRn = 1'b1;
        tick();

        mult("m3x5", 4'd3, 4'd5, 8'd15, -1);
        mult("m15x15", 4'd15, 4'd15, 8'd225, -1);
        mult("m0x9", 4'd0, 4'd9, 8'd0, -1);
        mult("m9x13", 4'd9, 4'd13, 8'd117, -1);
        mult("ign_start", 4'd3, 4'd5, 8'd15, 1);
        mult("m15x15b", 4'd15, 4'd15, 8'd225, -1);

        // Back-to-back with start held high
        d1 = -1; d2 = -1; n_done = 0; p1 = 8'h00; p2 = 8'h00;
        A = 4'd2;
        B = 4'd7;
        start = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (done === 1'b1) begin
                n_done++;
                if (d1 < 0) begin
                    d1 = i;
                    p1 = P;
                    A = 4'd4;
                    B = 4'd4;
                end else begin
                    d2 = i;
                    p2 = P;
                    start = 1'b0;
                end
            end
            tick();
        end
        start = 1'b0;
        check("b2b_p1", 16'(p1), 16'd14);
        check("b2b_p2", 16'(p2), 16'd16);
        check("b2b_first_edge", 16'(d1), 16'd4);
        check("b2b_spacing", 16'(d2 - d1), 16'd6);
        check("b2b_done_cnt", 16'(n_done), 16'd2);
        check("b2b_idle", 16'(busy), 16'd0);

        // Abort during the third CALC cycle (P is 16 beforehand)
        A = 4'd3;
        B = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_busy_pre", 16'(busy), 16'd1);
        #2;
        CLRn = 1'b0;
        #1;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        check("abort_p", 16'(P), 16'd0);
        #2;
        CLRn = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        check("abort_no_done", 16'(stray), 16'd0);
        check("abort_p_stays", 16'(P), 16'd0);
        mult("after_abort", 4'd3, 4'd5, 8'd15, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
